ifetch: RTL and testbench

Instruction fetch unit: the reader side of the instruction ROM. It owns the program counter and drives the ROM address. The ROM returns instruction data combinationally in the same cycle, and the fetch unit captures each word into a small prefetch FIFO. It presents instructions to the decode stage over a valid/ready handshake, and accepts PC redirects (branch, jump) from execute.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/ifetch.sv | 76 +++++++
 tb/tb_ifetch.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one prefetch FIFO entry, the fetch PC and its ROM word
//   PC_STEP       : byte distance between consecutive instructions
//   INSTR_NOP     : canonical no-op encoding (addi x0, x0, 0)
//   align_pc      : clears the byte-offset bits of an address
package ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Masking (rather than concatenating) keeps every input bit in use.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush.
//   clk, rst : clock, synchronous active-high reset (also clears storage)
//   push, din: write din when not full, or when full and popping
//   pop      : discard the head entry (ignored while empty)
//   flush    : drop every entry; wins over push and pop
//   full, empty, head : status and the entry at the read pointer
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests so the FIFO can never overflow or underflow on its own.
  always_comb begin
    pop_ok_s  = pop && (count_r != {(PTR_W+1){1'b0}});
    push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
  end

  // Storage, pointers and occupancy; flush resets bookkeeping but keeps data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == {(PTR_W+1){1'b0}});
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit, reader side of a combinational ROM.
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : ROM byte address, always the current PC
//   imem_data       : ROM word for imem_addr, same cycle
//   redirect_valid  : one-cycle pulse, load redirect_pc and flush prefetch
//   redirect_pc     : redirect target, low two bits ignored
//   instr_valid     : prefetch head holds an instruction
//   instr_ready     : decode takes the head this cycle
//   instr, instr_pc : head instruction word and its PC
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  logic [31:0]  pc_r;
  logic         pop_s;
  logic         push_s;
  logic         full_s;
  logic         empty_s;
  fetch_entry_t wr_entry_s;
  fetch_entry_t head_s;

  // A redirect cycle neither transfers to decode nor fetches; a full FIFO
  // may still fetch when the head leaves in the same cycle.
  always_comb begin
    pop_s      = !empty_s && instr_ready && !redirect_valid;
    push_s     = !redirect_valid && (!full_s || pop_s);
    wr_entry_s = '{pc: pc_r, instr: imem_data};
  end

  // Program counter: reset, redirect, advance on fetch, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= align_pc(redirect_pc);
    end else if (push_s) begin
      pc_r <= pc_r + PC_STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .din   (wr_entry_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  assign imem_addr   = pc_r;
  assign instr_valid = !empty_s;
  assign instr       = head_s.instr;
  assign instr_pc    = head_s.pc;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: scoreboard bench for ifetch. The reference model keeps the
// expected prefetch contents as a queue of {pc, word}; the monitor compares
// the DUT head, valid and ROM address against it every cycle and retires an
// entry on each handshake.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks = 0;
  int failures = 0;

  logic [31:0]  rom_mem [64];
  fetch_entry_t exp_q [$];
  logic [31:0]  m_pc = 32'h0;
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return rom_mem[a[7:2]] ^ a;
  endfunction

  assign imem_data = rom_word(imem_addr);

  ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: at each edge apply reset, redirect, or fetch-if-room.
  // Entries leaving via handshake were already retired by the monitor.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_pc   = RESET_PC;
      mon_en = 1'b1;
    end else if (mon_en) begin
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (exp_q.size() < DEPTH) begin
        exp_q.push_back('{pc: m_pc, instr: rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Monitor: sample mid-cycle after the driver has settled its inputs.
  initial forever begin
    fetch_entry_t e;
    bit m_valid;
    @(negedge clk);
    #2;
    if (mon_en) begin
      m_valid = (exp_q.size() != 0);
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
      chk("imem_addr", imem_addr, m_pc);
      if (m_valid) begin
        e = exp_q[0];
        if (instr_valid) begin
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.instr);
        end
        if (instr_ready && !redirect_valid && !rst) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst            = r;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;

    // Reset then straight-line fetch with decode always ready.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Backpressure from reset, then release.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect while the FIFO holds 0x4 and 0x8.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h20);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect with ready asserted in the same cycle.
    step(1'b0, 1'b1, 1'b1, 32'h1F);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // PC wrap-around.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Reset with a concurrent redirect while full.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
    end

    step(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
